// File: rtl/gate_exerciser.sv
// Self-test driver/checker for a two-input, seven-output logic-gate block.
// Walks A/B through 00,01,10,11, samples the gate outputs after a settle delay, and accumulates sticky results.
module gate_exerciser #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a_drv,
   output logic       b_drv,
   input  logic       cmp_and,
   input  logic       cmp_nand,
   input  logic       cmp_or,
   input  logic       cmp_nor,
   input  logic       cmp_not,
   input  logic       cmp_xor,
   input  logic       cmp_xnor,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [6:0] fail_mask,
   output logic [3:0] fail_vec,
   output logic [4:0] err_count
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRIVE  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

   // Truth table in fail_mask bit order: and, nand, or, nor, not, xor, xnor.
   function automatic logic [6:0] expected_outputs(input logic a, input logic b);
      expected_outputs = {~(a ^ b), a ^ b, ~a, ~(a | b), a | b, ~(a & b), a & b};
   endfunction

   function automatic logic [2:0] popcount7(input logic [6:0] v);
      logic [2:0] sum;
      sum = 3'd0;
      for (int i = 0; i < 7; i++) begin
         sum = sum + {2'b00, v[i]};
      end
      popcount7 = sum;
   endfunction

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic       a_q, a_d, b_q, b_d;
   logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [6:0] mask_q, mask_d;
   logic [3:0] vec_q, vec_d;
   logic [4:0] err_q, err_d;
   logic [6:0] mismatch_s;

   assign mismatch_s = {cmp_xnor, cmp_xor, cmp_not, cmp_nor, cmp_or, cmp_nand, cmp_and}
                       ^ expected_outputs(idx_q[1], idx_q[0]);

   // State register and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
         cnt_q   <= 4'd0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         mask_q  <= 7'd0;
         vec_q   <= 4'd0;
         err_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         mask_q  <= mask_d;
         vec_q   <= vec_d;
         err_q   <= err_d;
      end
   end

   // Next-state and result update logic.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      mask_d  = mask_q;
      vec_d   = vec_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_DRIVE;
               idx_d   = 2'd0;
               cnt_d   = 4'd0;
               a_d     = 1'b0;
               b_d     = 1'b0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               mask_d  = 7'd0;
               vec_d   = 4'd0;
               err_d   = 5'd0;
            end else begin
               state_d = state_q;
            end
         end
         ST_DRIVE: begin
            cnt_d = 4'd0;
            if (SETTLE_CYCLES == 0) begin
               state_d = ST_SAMPLE;
            end else begin
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q >= SETTLE_LAST) begin
               state_d = ST_SAMPLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_SAMPLE: begin
            mask_d = mask_q | mismatch_s;
            vec_d  = vec_q | ({3'b000, |mismatch_s} << idx_q);
            err_d  = err_q + {2'b00, popcount7(mismatch_s)};
            if (idx_q == 2'd3) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == 5'd0);
            end else begin
               // Next vector is driven on the same edge that leaves SAMPLE.
               idx_d   = idx_q + 2'd1;
               a_d     = idx_d[1];
               b_d     = idx_d[0];
               state_d = ST_DRIVE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign a_drv     = a_q;
   assign b_drv     = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_mask = mask_q;
   assign fail_vec  = vec_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench: two exercisers (settle 2 and settle 0) each driving a behavioural gate block with selectable faults.
module tb_gate_exerciser;

   logic       clk;
   logic       rst_n;
   logic [1:0] start_w;
   logic [1:0] a_w, b_w, busy_w, done_w, pass_w;
   logic [6:0] mask_w [2];
   logic [3:0] vec_w  [2];
   logic [4:0] err_w  [2];
   logic [6:0] cmp_w  [2];
   int         fault_w [2];
   int         n_cmp;
   int         n_fail;

   // Gate block model; fault 1 = xor stuck 0, 2 = not wired to B, 3 = all inverted.
   function automatic logic [6:0] gate_model(input logic a, input logic b, input int fault);
      logic [6:0] g;
      g = {~(a ^ b), a ^ b, ~a, ~(a | b), a | b, ~(a & b), a & b};
      case (fault)
         1: g[5] = 1'b0;
         2: g[4] = b;
         3: g = ~g;
         default: g = g;
      endcase
      return g;
   endfunction

   always_comb cmp_w[0] = gate_model(a_w[0], b_w[0], fault_w[0]);
   always_comb cmp_w[1] = gate_model(a_w[1], b_w[1], fault_w[1]);

   gate_exerciser #(.SETTLE_CYCLES(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_w[0]),
      .a_drv(a_w[0]), .b_drv(b_w[0]),
      .cmp_and(cmp_w[0][0]), .cmp_nand(cmp_w[0][1]), .cmp_or(cmp_w[0][2]), .cmp_nor(cmp_w[0][3]),
      .cmp_not(cmp_w[0][4]), .cmp_xor(cmp_w[0][5]), .cmp_xnor(cmp_w[0][6]),
      .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
      .fail_mask(mask_w[0]), .fail_vec(vec_w[0]), .err_count(err_w[0])
   );

   gate_exerciser #(.SETTLE_CYCLES(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_w[1]),
      .a_drv(a_w[1]), .b_drv(b_w[1]),
      .cmp_and(cmp_w[1][0]), .cmp_nand(cmp_w[1][1]), .cmp_or(cmp_w[1][2]), .cmp_nor(cmp_w[1][3]),
      .cmp_not(cmp_w[1][4]), .cmp_xor(cmp_w[1][5]), .cmp_xnor(cmp_w[1][6]),
      .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
      .fail_mask(mask_w[1]), .fail_vec(vec_w[1]), .err_count(err_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_idle_zero(input int d, input string name);
      n_cmp++;
      if ({a_w[d], b_w[d], busy_w[d], done_w[d], pass_w[d], mask_w[d], vec_w[d], err_w[d]} !== 23'd0) begin
         n_fail++;
         $display("FAIL %s dut%0d: a=%b b=%b busy=%b done=%b pass=%b mask=%b vec=%b err=%0d, required all zero",
                  name, d, a_w[d], b_w[d], busy_w[d], done_w[d], pass_w[d], mask_w[d], vec_w[d], err_w[d]);
      end
   endtask

   // One full run on dut d; checks vector sequence, done timing and final results.
   task automatic run_check(input int d, input int fault, input bit extra_starts,
                            input logic [6:0] exp_mask, input logic [3:0] exp_vec,
                            input logic [4:0] exp_err, input logic exp_pass, input string name);
      int period;
      int total;
      logic [1:0] exp_ab;
      period = (d == 0) ? 4 : 2;
      total  = 4 * period;
      fault_w[d] = fault;
      @(negedge clk);
      start_w[d] = 1'b1;
      @(posedge clk);
      #1;
      start_w[d] = 1'b0;
      n_cmp++;
      if ({busy_w[d], done_w[d], pass_w[d], a_w[d], b_w[d], mask_w[d], vec_w[d], err_w[d]} !== {3'b100, 2'b00, 16'd0}) begin
         n_fail++;
         $display("FAIL %s start_edge: busy=%b done=%b pass=%b ab=%b%b mask=%b vec=%b err=%0d, required busy=1 rest 0",
                  name, busy_w[d], done_w[d], pass_w[d], a_w[d], b_w[d], mask_w[d], vec_w[d], err_w[d]);
      end
      for (int i = 1; i <= total; i++) begin
         @(posedge clk);
         #1;
         start_w[d] = (extra_starts && (i == 3 || i == 5)) ? 1'b1 : 1'b0;
         if (i < total) begin
            n_cmp++;
            if (busy_w[d] !== 1'b1 || done_w[d] !== 1'b0) begin
               n_fail++;
               $display("FAIL %s busy_cycle%0d: busy=%b done=%b, required busy=1 done=0", name, i, busy_w[d], done_w[d]);
            end
            if (i % period == 0) begin
               exp_ab = 2'(i / period);
               n_cmp++;
               if ({a_w[d], b_w[d]} !== exp_ab) begin
                  n_fail++;
                  $display("FAIL %s vector_drive cycle%0d: ab=%b%b, required %b", name, i, a_w[d], b_w[d], exp_ab);
               end
            end
         end else begin
            n_cmp++;
            if ({busy_w[d], done_w[d], pass_w[d], a_w[d], b_w[d]} !== {2'b01, exp_pass, 2'b11}) begin
               n_fail++;
               $display("FAIL %s done_edge: busy=%b done=%b pass=%b ab=%b%b, required busy=0 done=1 pass=%b ab=11",
                        name, busy_w[d], done_w[d], pass_w[d], a_w[d], b_w[d], exp_pass);
            end
            n_cmp++;
            if (mask_w[d] !== exp_mask || vec_w[d] !== exp_vec || err_w[d] !== exp_err) begin
               n_fail++;
               $display("FAIL %s results: mask=%b vec=%b err=%0d, required mask=%b vec=%b err=%0d",
                        name, mask_w[d], vec_w[d], err_w[d], exp_mask, exp_vec, exp_err);
            end
         end
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (done_w[d] !== 1'b1 || pass_w[d] !== exp_pass || err_w[d] !== exp_err) begin
         n_fail++;
         $display("FAIL %s done_hold: done=%b pass=%b err=%0d, required done=1 pass=%b err=%0d",
                  name, done_w[d], pass_w[d], err_w[d], exp_pass, exp_err);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      check_idle_zero(0, "reset");
      check_idle_zero(1, "reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_good();
      run_check(0, 0, 1'b0, 7'd0, 4'd0, 5'd0, 1'b1, "good_settle2");
   endtask

   task automatic test_faults();
      run_check(0, 1, 1'b0, 7'b0100000, 4'b0110, 5'd2, 1'b0, "xor_stuck0");
      run_check(0, 2, 1'b0, 7'b0010000, 4'b1001, 5'd2, 1'b0, "not_wired_b");
      run_check(0, 3, 1'b0, 7'h7F, 4'hF, 5'd28, 1'b0, "all_inverted");
   endtask

   task automatic test_restart_from_done();
      run_check(0, 0, 1'b0, 7'd0, 4'd0, 5'd0, 1'b1, "restart_from_done");
   endtask

   task automatic test_settle0_back_to_back();
      run_check(1, 0, 1'b1, 7'd0, 4'd0, 5'd0, 1'b1, "settle0_extra_starts");
      run_check(1, 3, 1'b0, 7'h7F, 4'hF, 5'd28, 1'b0, "settle0_inverted");
   endtask

   task automatic test_reset_mid_run();
      fault_w[0] = 1;
      @(negedge clk);
      start_w[0] = 1'b1;
      @(posedge clk);
      #1;
      start_w[0] = 1'b0;
      // Nine edges after start puts dut0 in the first cycle of vector 2 SETTLE.
      for (int i = 0; i < 9; i++) begin
         @(posedge clk);
      end
      #1;
      n_cmp++;
      if ({a_w[0], b_w[0], busy_w[0], err_w[0], vec_w[0]} !== {2'b10, 1'b1, 5'd1, 4'b0010}) begin
         n_fail++;
         $display("FAIL mid_run_state: ab=%b%b busy=%b err=%0d vec=%b, required ab=10 busy=1 err=1 vec=0010",
                  a_w[0], b_w[0], busy_w[0], err_w[0], vec_w[0]);
      end
      rst_n = 1'b0;
      #1;
      check_idle_zero(0, "reset_mid_run");
      @(negedge clk);
      rst_n = 1'b1;
      run_check(0, 0, 1'b0, 7'd0, 4'd0, 5'd0, 1'b1, "fresh_after_reset");
   endtask

   initial begin
      n_cmp      = 0;
      n_fail     = 0;
      start_w    = 2'b00;
      fault_w[0] = 0;
      fault_w[1] = 0;
      rst_n      = 1'b0;
      test_reset();
      test_good();
      test_faults();
      test_restart_from_done();
      test_settle0_back_to_back();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/gate_exerciser.md
Name: gate_exerciser

Overview:
- Sequential stimulus/check initiator for the seven-output two-input logic-gate block (AND, NAND, OR, NOR, NOT, XOR, XNOR).
- Drives A and B through all four input combinations. After a settle delay, samples the seven gate outputs and compares each against the expected truth table.
- Reports per-gate and per-vector failures, a mismatch count and a pass flag.
- Sits beside the gate block as its driver/checker for on-board self-test.

Parameters:
- SETTLE_CYCLES, 2, idle cycles between driving a vector and sampling the outputs; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a test run; sampled on rising clk.
- a_drv  output  1  drive to gate block input A.
- b_drv  output  1  drive to gate block input B.
- cmp_and, cmp_nand, cmp_or, cmp_nor, cmp_not, cmp_xor, cmp_xnor  input  1 each  gate block outputs under test.
- busy  output  1  high while a run is in progress.
- done  output  1  high in DONE state; held until the next run starts or reset.
- pass  output  1  high only in DONE when err_count==0.
- fail_mask  output  7  sticky per-gate failure; bit order [0]and [1]nand [2]or [3]nor [4]not [5]xor [6]xnor.
- fail_vec  output  4  sticky per-vector failure; bit n = vector n had at least one mismatch.
- err_count  output  5  number of mismatching (gate, vector) pairs; range 0..28.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; a_drv=b_drv=0; busy=done=pass=0; fail_mask=0; fail_vec=0; err_count=0; vector index=0; settle counter=0.
- Vector n (n=0..3): a_drv=n[1], b_drv=n[0].
- Expected outputs per vector: and=A&B, nand=~(A&B), or=A|B, nor=~(A|B), not=~A, xor=A^B, xnor=~(A^B).
- All outputs are registered.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE, start=1 at edge k: enter DRIVE; index=0; a_drv/b_drv take vector 0; busy=1; fail_mask, fail_vec and err_count are cleared.
- DRIVE: one cycle.
  - Goes to SETTLE with settle counter=0 if SETTLE_CYCLES>0.
  - Goes directly to SAMPLE if SETTLE_CYCLES=0.
- SETTLE: stays exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE: one cycle. On its exit edge, compares the seven inputs against expected values for the current index:
  - each mismatching gate sets its fail_mask bit;
  - any mismatch sets fail_vec[index];
  - err_count increases by the number of mismatches in that vector (0..7).
- SAMPLE exit, index<3: index++ and go to DRIVE, with a_drv/b_drv updated to the new vector on that same edge.
- SAMPLE exit, index==3: go to DONE; busy=0; done=1; pass=(final err_count==0); a_drv/b_drv hold vector 3.
- Timing: each vector takes SETTLE_CYCLES+2 cycles. done rises on edge k+4*(SETTLE_CYCLES+2), i.e. 16 cycles after the start edge for the default.
- DONE: done, pass and the result registers hold.
  - start=1 restarts exactly as from IDLE: done and pass drop, results are cleared on that edge.
- start while busy (DRIVE/SETTLE/SAMPLE): ignored; no restart, no effect on results.
- Inputs are compared only on the SAMPLE exit edge. Glitches on cmp_* in DRIVE/SETTLE have no effect.
- Reset mid-run: immediate return to reset values. No partial results are retained.
- err_count cannot overflow (maximum 28 fits in 5 bits).

Test Plan:
- Correct gate block, SETTLE_CYCLES=2, start pulse -> a_drv/b_drv sequence 00,01,10,11; done=1 16 cycles after start edge; pass=1; err_count=0; fail_mask=0; fail_vec=0.
- cmp_xor stuck at 0 -> fail_mask=7'b0100000, fail_vec=4'b0110, err_count=2, pass=0.
- cmp_not wired to B instead of ~A -> fail_mask=7'b0010000, fail_vec=4'b1001, err_count=2, pass=0.
- All seven outputs inverted -> fail_mask=7'h7F, fail_vec=4'hF, err_count=28, pass=0.
- SETTLE_CYCLES=0 with correct block -> done 8 cycles after start edge, pass=1. Extra start pulses while busy=1 -> same timing and results.
- Reset asserted during vector 2 SETTLE -> all outputs 0 immediately.
  - New start after reset -> full fresh run, pass=1.
  - start in DONE after a failing run -> results cleared on that edge; rerun against a correct block ends with pass=1.
